// File: rtl/rd_port_arbiter.sv
// rd_port_arbiter: round-robin share of one read engine among NUM_REQ clients.
// Ports: clk/rst, req in, gnt/done out, eng_go/eng_ds engine, busy/tmo/err_flag/err_id status.
module rd_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       eng_go,
  input  logic                       eng_ds,
  output logic                       busy,
  output logic                       tmo,
  output logic                       err_flag,
  output logic [$clog2(NUM_REQ)-1:0] err_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WW-1:0] WLAST =
    (TIMEOUT_CYC > 0) ? WW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GRANT = 3'b010,
    WAIT  = 3'b100
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]      ptr, ptr_nxt;
  logic [IW-1:0]      win, win_nxt;
  logic [WW-1:0]      wcnt, wcnt_nxt;
  logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
  logic               go_nxt, busy_nxt, tmo_nxt;
  logic               err_nxt;
  logic [IW-1:0]      err_id_nxt;

  logic               found;
  logic [IW-1:0]      pick;
  logic [IW:0]        cand;
  logic [IW-1:0]      win_inc;

  // Rotating priority search starting at ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ))
        cand = cand - (IW+1)'(NUM_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  assign win_inc = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    win_nxt    = win;
    wcnt_nxt   = wcnt;
    gnt_nxt    = gnt;
    done_nxt   = '0;
    go_nxt     = 1'b0;
    busy_nxt   = busy;
    tmo_nxt    = 1'b0;
    err_nxt    = err_flag;
    err_id_nxt = err_id;
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (found) begin
          state_nxt = GRANT;
          win_nxt   = pick;
          gnt_nxt   = NUM_REQ'(1) << pick;
          go_nxt    = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        state_nxt = WAIT;
        wcnt_nxt  = '0;
      end
      WAIT: begin
        // A done strobe beats a watchdog expiry on the same edge.
        if (eng_ds) begin
          state_nxt     = IDLE;
          gnt_nxt       = '0;
          done_nxt[win] = 1'b1;
          ptr_nxt       = win_inc;
          busy_nxt      = 1'b0;
        end else if (TIMEOUT_CYC != 0 && wcnt == WLAST) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          tmo_nxt    = 1'b1;
          err_nxt    = 1'b1;
          err_id_nxt = win;
          ptr_nxt    = win_inc;
          busy_nxt   = 1'b0;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      default: begin
        // Corrupted encoding: fall back to IDLE, sticky error kept.
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      wcnt     <= '0;
      gnt      <= '0;
      done     <= '0;
      eng_go   <= 1'b0;
      busy     <= 1'b0;
      tmo      <= 1'b0;
      err_flag <= 1'b0;
      err_id   <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      win      <= win_nxt;
      wcnt     <= wcnt_nxt;
      gnt      <= gnt_nxt;
      done     <= done_nxt;
      eng_go   <= go_nxt;
      busy     <= busy_nxt;
      tmo      <= tmo_nxt;
      err_flag <= err_nxt;
      err_id   <= err_id_nxt;
    end
  end

endmodule
